// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//
// One requester port of the data-BRAM arbiter. Each requester (exec load/store
// path, program loader) gets its own instance.
//
// Signals:
//   req    requester -> arbiter  access request
//   we     requester -> arbiter  byte write enables, 4'b0000 = read
//   addr   requester -> arbiter  word address
//   wdata  requester -> arbiter  lane-replicated write data
//   gnt    arbiter -> requester  one-cycle accept pulse
//   rvalid arbiter -> requester  one-cycle read-return pulse
//   rdata  arbiter -> requester  read data, held until the next rvalid
//
// Handshake: req is a valid, gnt is its ready, and gnt is a registered
// acknowledge. The requester raises req with we/addr/wdata stable and keeps
// all four unchanged until it sees gnt high. The access is accepted on the
// edge that makes gnt high, so during the gnt cycle the requester may present
// a new access or drop req. A req still high at the next edge is a new
// access. Read returns carry no back-pressure: rvalid fires exactly once per
// accepted read and must be taken in that cycle.
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
  logic        req;
  logic [3:0]  we;
  logic [18:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  // Requester side.
  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  // Arbiter side.
  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single data-BRAM port between two requesters:
//   port0 : exec unit load/store path
//   port1 : program loader / instruction-fill path
// At most one access is accepted per cycle. Ties go round-robin, using the
// port that was not granted last. The winning access is registered straight
// into the BRAM address/write-enable/write-data registers. A tag pipeline
// follows every accepted read through the BRAM latency, so each read result
// goes back only to the port that issued it.
//
// Parameters:
//   RD_LAT  BRAM read latency (1..3), counted from the edge the BRAM samples
//           mem_addr to the cycle mem_rdata is valid.
//
// Ports:
//   clk         clock, all logic on posedge
//   rstn        asynchronous active-low reset
//   port0       requester 0 (mem_arbiter_if.slave)
//   port1       requester 1 (mem_arbiter_if.slave)
//   mem_enable  BRAM enable, constant 1
//   mem_addr    registered BRAM word address
//   mem_wea     registered BRAM byte write enables
//   mem_wdata   registered BRAM write data
//   mem_rdata   BRAM read data
//   dbg_last    round-robin state: port granted most recently
//
// Timing with a grant at edge E0: gnt is high in the cycle after E0, and the
// BRAM samples the access at E1. For a read, rdata/rvalid are registered at
// E(1+RD_LAT), so rvalid is high RD_LAT+1 cycles after gnt.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rstn,
  mem_arbiter_if.slave  port0,
  mem_arbiter_if.slave  port1,
  output logic          mem_enable,
  output logic [18:0]   mem_addr,
  output logic [3:0]    mem_wea,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          dbg_last
);

  // ---------------------------------------------------------------------------
  // Round-robin state. last_q = port granted most recently. Its reset value
  // of 1 makes port 0 win the first tie. It only changes on a grant.
  // ---------------------------------------------------------------------------
  logic last_q;

  // Arbitration result for the current edge.
  logic        win0;
  logic        win1;
  logic        any_win;
  logic [3:0]  win_we;
  logic [18:0] win_addr;
  logic [31:0] win_wdata;
  logic        push_vld;

  // Read tags. Stage 0 is loaded on the grant edge. Stage RD_LAT lines up
  // with the cycle in which mem_rdata holds that read's data.
  logic [RD_LAT:0] tag_vld_q;
  logic [RD_LAT:0] tag_own_q;

  assign mem_enable = 1'b1;
  assign dbg_last   = last_q;

  // ---------------------------------------------------------------------------
  // Arbitration: a lone requester wins. On a tie, the port not granted last
  // wins. win1 is derived from win0, so the two can never both be set.
  // ---------------------------------------------------------------------------
  always_comb begin
    win0      = port0.req & (~port1.req | last_q);
    win1      = port1.req & ~win0;
    any_win   = win0 | win1;
    win_we    = port0.we;
    win_addr  = port0.addr;
    win_wdata = port0.wdata;
    if (win1) begin
      win_we    = port1.we;
      win_addr  = port1.addr;
      win_wdata = port1.wdata;
    end
    // Only reads carry a valid tag. Writes and idle cycles push a bubble.
    push_vld = any_win & (win_we == 4'b0000);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q <= 1'b1;
    end else if (any_win) begin
      last_q <= win1;
    end
  end

  // ---------------------------------------------------------------------------
  // Grant pulses and the BRAM access registers. With no winner, mem_wea
  // drops to 0 so each accepted write is presented for exactly one cycle.
  // Address and data hold their values.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      port0.gnt <= 1'b0;
      port1.gnt <= 1'b0;
      mem_addr  <= 19'h0;
      mem_wea   <= 4'b0000;
      mem_wdata <= 32'h0;
    end else begin
      port0.gnt <= win0;
      port1.gnt <= win1;
      if (any_win) begin
        mem_addr  <= win_addr;
        mem_wea   <= win_we;
        mem_wdata <= win_wdata;
      end else begin
        mem_wea   <= 4'b0000;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipeline. Exactly one push and one pop happen every cycle, so it
  // cannot overflow. Reset clears it, so reads in flight at reset never
  // produce an rvalid.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_vld_q <= '0;
      tag_own_q <= '0;
    end else begin
      tag_vld_q <= {tag_vld_q[RD_LAT-1:0], push_vld};
      tag_own_q <= {tag_own_q[RD_LAT-1:0], win1};
    end
  end

  // ---------------------------------------------------------------------------
  // Read return: the tail tag steers mem_rdata to its owner. Each rdata
  // register only loads on its own rvalid, so it holds between returns.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      port0.rvalid <= 1'b0;
      port1.rvalid <= 1'b0;
      port0.rdata  <= 32'h0;
      port1.rdata  <= 32'h0;
    end else begin
      port0.rvalid <= tag_vld_q[RD_LAT] & ~tag_own_q[RD_LAT];
      port1.rvalid <= tag_vld_q[RD_LAT] &  tag_own_q[RD_LAT];
      if (tag_vld_q[RD_LAT] && !tag_own_q[RD_LAT]) begin
        port0.rdata <= mem_rdata;
      end
      if (tag_vld_q[RD_LAT] && tag_own_q[RD_LAT]) begin
        port1.rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter with RD_LAT = 1. A behavioural BRAM is attached to
// the mem_* port and preloaded with value = address, plus 32'h11223344 at
// word 5. Sequences:
//   1. reset values with both requests held, then release ordering
//   2. table of per-cycle vectors with hand-computed outputs
//   3. read in flight cut off by a reset pulse
//   4. random mixed traffic against a reference memory and expected queues
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int RD_LAT = 1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if p0 ();
  mem_arbiter_if p1 ();

  logic        mem_enable;
  logic [18:0] mem_addr;
  logic [3:0]  mem_wea;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        dbg_last;

  mem_arbiter #(.RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .port0      (p0),
    .port1      (p1),
    .mem_enable (mem_enable),
    .mem_addr   (mem_addr),
    .mem_wea    (mem_wea),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .dbg_last   (dbg_last)
  );

  // ---------------------------------------------------------------------------
  // Behavioural BRAM: read-first, byte writes, RD_LAT-deep output pipe.
  // It preloads itself on the first edge, while reset is still low.
  // ---------------------------------------------------------------------------
  logic [31:0] bram    [0:1023];
  logic [31:0] rd_pipe [0:RD_LAT-1];
  logic        loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) bram[i] <= 32'(i);
      bram[5] <= 32'h11223344;
      loaded  <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_wea[b]) bram[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    rd_pipe[0] <= bram[mem_addr[9:0]];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign mem_rdata = rd_pipe[RD_LAT-1];

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check helper
  // ---------------------------------------------------------------------------
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        r0;  logic [3:0] we0; logic [18:0] a0; logic [31:0] d0;
    logic        r1;  logic [3:0] we1; logic [18:0] a1; logic [31:0] d1;
    logic        g0;  logic       g1;  logic [3:0]  wea;
    logic [18:0] maddr; logic [31:0] mwd;
    logic        v0;  logic [31:0] rd0;
    logic        v1;  logic [31:0] rd1;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic r0, input logic [3:0] we0, input logic [18:0] a0, input logic [31:0] d0,
    input logic r1, input logic [3:0] we1, input logic [18:0] a1, input logic [31:0] d1,
    input logic g0, input logic g1, input logic [3:0] wea,
    input logic [18:0] maddr, input logic [31:0] mwd,
    input logic v0, input logic [31:0] rd0, input logic v1, input logic [31:0] rd1);
    vec_t v;
    v.r0 = r0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.wea = wea; v.maddr = maddr; v.mwd = mwd;
    v.v0 = v0; v.rd0 = rd0; v.v1 = v1; v.rd1 = rd1;
    return v;
  endfunction

  // Driver helpers
  task automatic drive0(input logic r, input logic [3:0] we, input logic [18:0] a, input logic [31:0] d);
    p0.req = r; p0.we = we; p0.addr = a; p0.wdata = d;
  endtask

  task automatic drive1(input logic r, input logic [3:0] we, input logic [18:0] a, input logic [31:0] d);
    p1.req = r; p1.we = we; p1.addr = a; p1.wdata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random-traffic reference: words 64..95, untouched by the earlier tests.
  logic [31:0] ref_mem [0:31];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Test 1: reset held with both ports requesting.
    drive0(1'b1, 4'h0, 19'd2, 32'h0);
    drive1(1'b1, 4'h0, 19'd3, 32'h0);
    repeat (3) tick();
    chk("rst_gnt0",   32'(p0.gnt),    32'h0);
    chk("rst_gnt1",   32'(p1.gnt),    32'h0);
    chk("rst_rv0",    32'(p0.rvalid), 32'h0);
    chk("rst_rv1",    32'(p1.rvalid), 32'h0);
    chk("rst_rdata0", p0.rdata,       32'h0);
    chk("rst_rdata1", p1.rdata,       32'h0);
    chk("rst_wdata",  mem_wdata,      32'h0);
    chk("rst_addr",   32'(mem_addr),  32'h0);
    chk("rst_wea",    32'(mem_wea),   32'h0);
    chk("rst_en",     32'(mem_enable), 32'h1);
    chk("rst_last",   32'(dbg_last),  32'h1);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("rel_gnt0_e1", 32'(p0.gnt), 32'h1);
    chk("rel_gnt1_e1", 32'(p1.gnt), 32'h0);
    chk("rel_addr_e1", 32'(mem_addr), 32'd2);
    drive0(1'b0, 4'h0, 19'd0, 32'h0);
    tick();
    chk("rel_gnt0_e2", 32'(p0.gnt), 32'h0);
    chk("rel_gnt1_e2", 32'(p1.gnt), 32'h1);
    chk("rel_addr_e2", 32'(mem_addr), 32'd3);
    drive1(1'b0, 4'h0, 19'd0, 32'h0);
    tick();
    chk("rel_rv0",    32'(p0.rvalid), 32'h1);
    chk("rel_rdata0", p0.rdata,       32'd2);
    chk("rel_rv1_0",  32'(p1.rvalid), 32'h0);
    tick();
    chk("rel_rv1",    32'(p1.rvalid), 32'h1);
    chk("rel_rdata1", p1.rdata,       32'd3);
    chk("rel_rv0_0",  32'(p0.rvalid), 32'h0);
    repeat (2) tick();

    // Test 2: vector table.
    //                r0 we0  a0     d0            r1 we1  a1     d1            g0 g1 wea   maddr  mwd           v0 rd0           v1 rd1
    vecs[0]  = mk(1, 4'hF, 19'h10, 32'hDEADBEEF, 0, 4'h0, 19'd0, 32'h0,         1, 0, 4'hF, 19'h10, 32'hDEADBEEF, 0, 32'h0,        0, 32'h0);
    vecs[1]  = mk(1, 4'h0, 19'h10, 32'h0,        0, 4'h0, 19'd0, 32'h0,         1, 0, 4'h0, 19'h10, 32'h0,        0, 32'h0,        0, 32'h0);
    vecs[2]  = mk(0, 4'h0, 19'd0,  32'h0,        0, 4'h0, 19'd0, 32'h0,         0, 0, 4'h0, 19'h10, 32'h0,        0, 32'h0,        0, 32'h0);
    vecs[3]  = mk(0, 4'h0, 19'd0,  32'h0,        0, 4'h0, 19'd0, 32'h0,         0, 0, 4'h0, 19'h10, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0);
    vecs[4]  = mk(1, 4'h0, 19'd0,  32'h0,        1, 4'h0, 19'd100, 32'h0,       0, 1, 4'h0, 19'd100, 32'h0,       0, 32'h0,        0, 32'h0);
    vecs[5]  = mk(1, 4'h0, 19'd0,  32'h0,        1, 4'h0, 19'd101, 32'h0,       1, 0, 4'h0, 19'd0,  32'h0,        0, 32'h0,        0, 32'h0);
    vecs[6]  = mk(1, 4'h0, 19'd1,  32'h0,        1, 4'h0, 19'd101, 32'h0,       0, 1, 4'h0, 19'd101, 32'h0,       0, 32'h0,        1, 32'd100);
    vecs[7]  = mk(1, 4'h0, 19'd1,  32'h0,        1, 4'h0, 19'd102, 32'h0,       1, 0, 4'h0, 19'd1,  32'h0,        1, 32'd0,        0, 32'h0);
    vecs[8]  = mk(1, 4'h0, 19'd2,  32'h0,        1, 4'h0, 19'd102, 32'h0,       0, 1, 4'h0, 19'd102, 32'h0,       0, 32'h0,        1, 32'd101);
    vecs[9]  = mk(1, 4'h0, 19'd2,  32'h0,        0, 4'h0, 19'd0, 32'h0,         1, 0, 4'h0, 19'd2,  32'h0,        1, 32'd1,        0, 32'h0);
    vecs[10] = mk(0, 4'h0, 19'd0,  32'h0,        0, 4'h0, 19'd0, 32'h0,         0, 0, 4'h0, 19'd2,  32'h0,        0, 32'h0,        1, 32'd102);
    vecs[11] = mk(0, 4'h0, 19'd0,  32'h0,        0, 4'h0, 19'd0, 32'h0,         0, 0, 4'h0, 19'd2,  32'h0,        1, 32'd2,        0, 32'h0);
    vecs[12] = mk(0, 4'h0, 19'd0,  32'h0,        1, 4'h4, 19'd5, 32'hABABABAB,  0, 1, 4'h4, 19'd5,  32'hABABABAB, 0, 32'h0,        0, 32'h0);
    vecs[13] = mk(1, 4'h0, 19'd5,  32'h0,        0, 4'h0, 19'd0, 32'h0,         1, 0, 4'h0, 19'd5,  32'h0,        0, 32'h0,        0, 32'h0);
    vecs[14] = mk(0, 4'h0, 19'd0,  32'h0,        0, 4'h0, 19'd0, 32'h0,         0, 0, 4'h0, 19'd5,  32'h0,        0, 32'h0,        0, 32'h0);
    vecs[15] = mk(0, 4'h0, 19'd0,  32'h0,        0, 4'h0, 19'd0, 32'h0,         0, 0, 4'h0, 19'd5,  32'h0,        1, 32'h11AB3344, 0, 32'h0);
    vecs[16] = mk(0, 4'h0, 19'd0,  32'h0,        1, 4'h0, 19'd7, 32'h0,         0, 1, 4'h0, 19'd7,  32'h0,        0, 32'h0,        0, 32'h0);
    vecs[17] = mk(0, 4'h0, 19'd0,  32'h0,        1, 4'h0, 19'd8, 32'h0,         0, 1, 4'h0, 19'd8,  32'h0,        0, 32'h0,        0, 32'h0);
    vecs[18] = mk(1, 4'h0, 19'd9,  32'h0,        1, 4'h0, 19'd10, 32'h0,        1, 0, 4'h0, 19'd9,  32'h0,        0, 32'h0,        1, 32'd7);
    vecs[19] = mk(0, 4'h0, 19'd0,  32'h0,        1, 4'h0, 19'd10, 32'h0,        0, 1, 4'h0, 19'd10, 32'h0,        0, 32'h0,        1, 32'd8);
    vecs[20] = mk(0, 4'h0, 19'd0,  32'h0,        0, 4'h0, 19'd0, 32'h0,         0, 0, 4'h0, 19'd10, 32'h0,        1, 32'd9,        0, 32'h0);
    vecs[21] = mk(0, 4'h0, 19'd0,  32'h0,        0, 4'h0, 19'd0, 32'h0,         0, 0, 4'h0, 19'd10, 32'h0,        0, 32'h0,        1, 32'd10);

    for (int k = 0; k < NVEC; k++) begin
      drive0(vecs[k].r0, vecs[k].we0, vecs[k].a0, vecs[k].d0);
      drive1(vecs[k].r1, vecs[k].we1, vecs[k].a1, vecs[k].d1);
      tick();
      chk($sformatf("v%0d_gnt0", k), 32'(p0.gnt),    32'(vecs[k].g0));
      chk($sformatf("v%0d_gnt1", k), 32'(p1.gnt),    32'(vecs[k].g1));
      chk($sformatf("v%0d_wea",  k), 32'(mem_wea),   32'(vecs[k].wea));
      chk($sformatf("v%0d_addr", k), 32'(mem_addr),  32'(vecs[k].maddr));
      chk($sformatf("v%0d_rv0",  k), 32'(p0.rvalid), 32'(vecs[k].v0));
      chk($sformatf("v%0d_rv1",  k), 32'(p1.rvalid), 32'(vecs[k].v1));
      if (vecs[k].wea != 4'h0) chk($sformatf("v%0d_wdata", k), mem_wdata, vecs[k].mwd);
      if (vecs[k].v0) chk($sformatf("v%0d_rdata0", k), p0.rdata, vecs[k].rd0);
      if (vecs[k].v1) chk($sformatf("v%0d_rdata1", k), p1.rdata, vecs[k].rd1);
    end
    drive0(1'b0, 4'h0, 19'd0, 32'h0);
    drive1(1'b0, 4'h0, 19'd0, 32'h0);
    repeat (2) tick();

    // Test 3: read accepted, then reset before its data returns.
    drive0(1'b1, 4'h0, 19'd3, 32'h0);
    tick();
    chk("mid_gnt0", 32'(p0.gnt), 32'h1);
    chk("mid_addr", 32'(mem_addr), 32'd3);
    drive0(1'b0, 4'h0, 19'd0, 32'h0);
    rstn = 1'b0;
    #1;
    chk("mid_rst_addr", 32'(mem_addr), 32'h0);
    chk("mid_rst_gnt0", 32'(p0.gnt),   32'h0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("mid_no_rv0_c%0d", c), 32'(p0.rvalid), 32'h0);
      chk($sformatf("mid_no_rv1_c%0d", c), 32'(p1.rvalid), 32'h0);
    end

    // Test 4: random mixed traffic against a reference memory.
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'(64 + i);
    for (int cyc = 0; cyc < 10000 + 8; cyc++) begin
      tick();
      if (p0.rvalid) begin
        if (exp_q0.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL rnd_rv0_extra: got rvalid0 with rdata %h, required no return", p0.rdata);
        end else begin
          chk("rnd_rdata0", p0.rdata, exp_q0.pop_front());
        end
      end
      if (p1.rvalid) begin
        if (exp_q1.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL rnd_rv1_extra: got rvalid1 with rdata %h, required no return", p1.rdata);
        end else begin
          chk("rnd_rdata1", p1.rdata, exp_q1.pop_front());
        end
      end
      chk("rnd_one_gnt", 32'(p0.gnt & p1.gnt), 32'h0);
      if (p0.gnt) begin
        chk("rnd_addr0", 32'(mem_addr), 32'(p0.addr));
        if (p0.we == 4'h0) exp_q0.push_back(ref_mem[p0.addr - 19'd64]);
        else for (int b = 0; b < 4; b++)
          if (p0.we[b]) ref_mem[p0.addr - 19'd64][8*b +: 8] = p0.wdata[8*b +: 8];
        p0.req = 1'b0;
      end
      if (p1.gnt) begin
        chk("rnd_addr1", 32'(mem_addr), 32'(p1.addr));
        if (p1.we == 4'h0) exp_q1.push_back(ref_mem[p1.addr - 19'd64]);
        else for (int b = 0; b < 4; b++)
          if (p1.we[b]) ref_mem[p1.addr - 19'd64][8*b +: 8] = p1.wdata[8*b +: 8];
        p1.req = 1'b0;
      end
      // New requests only during the traffic window; the tail cycles drain.
      if (cyc < 10000) begin
        if (!p0.req && $urandom_range(0, 2) != 0)
          drive0(1'b1, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                 19'(64 + $urandom_range(0, 31)), $urandom);
        if (!p1.req && $urandom_range(0, 2) != 0)
          drive1(1'b1, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                 19'(64 + $urandom_range(0, 31)), $urandom);
      end
    end
    chk("rnd_q0_empty", 32'(exp_q0.size()), 32'h0);
    chk("rnd_q1_empty", 32'(exp_q1.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
